mem_port_initiator: RTL and testbench

- Clocked initiator for the processor-side data-memory port, driving the four-phase single-rail bundled-data channels Access, Mode, Do, Di and Abort.
- Converts one valid/ready request (read or write, byte/half/word) into the full channel handshake sequence, then returns read data and the abort flag on a valid/ready response.
- Sits between a synchronous CPU or test harness and the asynchronous dual-port memory model or its hardware equivalent.

---
 rtl/mem_port_pkg.sv | 30 +++
 rtl/mem_port_initiator_ack_sync.sv | 23 ++
 rtl/mem_port_initiator.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_initiator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared constants, access-word layout and FSM states for the data-memory port initiator.
package mem_port_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int RNW_BIT  = 0;
   localparam int ADDR_LSB = 1;
   localparam int SIZE_LSB = 33;
   localparam int ACCESS_W = 38;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_DATA,
      ST_RTZ,
      ST_RESP
   } state_e;

   // The reserved size encoding is presented to the memory as a word access.
   function automatic logic [1:0] normSize(input logic [1:0] size);
      case (size)
         SZ_BYTE, SZ_HALF, SZ_WORD: normSize = size;
         default:                   normSize = SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_initiator_ack_sync.sv
// Reset-to-zero flop chain bringing one asynchronous acknowledge into the clock domain.
module ack_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], async_i};
      end
   end

   assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/mem_port_initiator.sv
// Turns one valid/ready memory request into the four-phase Access/Mode/Do/Di/Abort handshake
// sequence and returns read data plus the abort flag on a valid/ready response.
module mem_port_initiator
   import mem_port_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_rnw,
   input  logic [31:0]         req_addr,
   input  logic [1:0]          req_size,
   input  logic                req_priv,
   input  logic [31:0]         req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         rsp_rdata,
   output logic                rsp_abort,
   output logic                hang,
   output logic                access_r,
   input  logic                access_a,
   output logic [ACCESS_W-1:0] access_d,
   output logic                mode_r,
   input  logic                mode_a,
   output logic                mode_d,
   output logic                do_r,
   input  logic                do_a,
   output logic [31:0]         do_d,
   output logic                di_r,
   input  logic                di_a,
   input  logic [31:0]         di_d,
   output logic                abort_r,
   input  logic                abort_a,
   input  logic                abort_d
);

   localparam int                WDOG_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES);

   state_e                state_q, state_d;
   logic                  rnw_q, rnw_d;
   logic [ACCESS_W-1:0]   accessData_q, accessData_d;
   logic                  modeData_q, modeData_d;
   logic [31:0]           doData_q, doData_d;
   logic [31:0]           rspRdata_q, rspRdata_d;
   logic                  rspAbort_q, rspAbort_d;
   logic [WDOG_W-1:0]     wdog_q, wdog_d;
   logic                  hang_q, hang_d;
   logic                  accessR_q, accessR_d;
   logic                  modeR_q, modeR_d;
   logic                  doR_q, doR_d;
   logic                  diR_q, diR_d;
   logic                  abortR_q, abortR_d;

   logic accessAck, modeAck, doAck, diAck, abortAck;
   logic allAcksLow;

   ack_sync #(.STAGES(SYNC_STAGES)) uSyncAccess (.clk(clk), .reset(reset), .async_i(access_a), .sync_o(accessAck));
   ack_sync #(.STAGES(SYNC_STAGES)) uSyncMode   (.clk(clk), .reset(reset), .async_i(mode_a),   .sync_o(modeAck));
   ack_sync #(.STAGES(SYNC_STAGES)) uSyncDo     (.clk(clk), .reset(reset), .async_i(do_a),     .sync_o(doAck));
   ack_sync #(.STAGES(SYNC_STAGES)) uSyncDi     (.clk(clk), .reset(reset), .async_i(di_a),     .sync_o(diAck));
   ack_sync #(.STAGES(SYNC_STAGES)) uSyncAbort  (.clk(clk), .reset(reset), .async_i(abort_a),  .sync_o(abortAck));

   assign allAcksLow = ~(accessAck | modeAck | doAck | diAck | abortAck);

   // Holding off new requests until every ack is low also covers a reset issued mid-handshake.
   assign req_ready = (state_q == ST_IDLE) && allAcksLow;

   always_comb begin
      state_d      = state_q;
      rnw_d        = rnw_q;
      accessData_d = accessData_q;
      modeData_d   = modeData_q;
      doData_d     = doData_q;
      rspRdata_d   = rspRdata_q;
      rspAbort_d   = rspAbort_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               rnw_d                              = req_rnw;
               accessData_d                       = '0;
               accessData_d[RNW_BIT]              = req_rnw;
               accessData_d[ADDR_LSB +: 32]       = req_addr;
               accessData_d[SIZE_LSB +: 2]        = normSize(req_size);
               modeData_d                         = req_priv;
               doData_d                           = req_rnw ? 32'd0 : req_wdata;
               state_d                            = ST_SETUP;
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (accessAck && modeAck) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rnw_q && diAck && abortAck) begin
               rspRdata_d = di_d;
               rspAbort_d = abort_d;
               state_d    = ST_RTZ;
            end else if (!rnw_q && doAck && abortAck) begin
               rspRdata_d = 32'd0;
               rspAbort_d = abort_d;
               state_d    = ST_RTZ;
            end
         end
         ST_RTZ: begin
            if (allAcksLow) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Requests are registered from the next state so they never glitch; do_r rises with access_r
   // because the memory withholds the Access ack on writes until write data is offered.
   always_comb begin
      accessR_d = (state_d == ST_ACCESS) || (state_d == ST_DATA);
      modeR_d   = accessR_d;
      doR_d     = accessR_d && !rnw_d;
      diR_d     = (state_d == ST_DATA) && rnw_d;
      abortR_d  = (state_d == ST_DATA);
   end

   always_comb begin
      wdog_d = wdog_q;
      if (state_d != state_q) begin
         wdog_d = '0;
      end else if (((state_q == ST_ACCESS) || (state_q == ST_DATA) || (state_q == ST_RTZ))
                   && (wdog_q != WDOG_MAX)) begin
         wdog_d = wdog_q + 1'b1;
      end
      hang_d = hang_q | (wdog_d == WDOG_MAX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rnw_q        <= 1'b0;
         accessData_q <= '0;
         modeData_q   <= 1'b0;
         doData_q     <= '0;
         rspRdata_q   <= '0;
         rspAbort_q   <= 1'b0;
         wdog_q       <= '0;
         hang_q       <= 1'b0;
         accessR_q    <= 1'b0;
         modeR_q      <= 1'b0;
         doR_q        <= 1'b0;
         diR_q        <= 1'b0;
         abortR_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         rnw_q        <= rnw_d;
         accessData_q <= accessData_d;
         modeData_q   <= modeData_d;
         doData_q     <= doData_d;
         rspRdata_q   <= rspRdata_d;
         rspAbort_q   <= rspAbort_d;
         wdog_q       <= wdog_d;
         hang_q       <= hang_d;
         accessR_q    <= accessR_d;
         modeR_q      <= modeR_d;
         doR_q        <= doR_d;
         diR_q        <= diR_d;
         abortR_q     <= abortR_d;
      end
   end

   assign access_r  = accessR_q;
   assign mode_r    = modeR_q;
   assign do_r      = doR_q;
   assign di_r      = diR_q;
   assign abort_r   = abortR_q;
   assign access_d  = accessData_q;
   assign mode_d    = modeData_q;
   assign do_d      = doData_q;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rspRdata_q;
   assign rsp_abort = rspAbort_q;
   assign hang      = hang_q;

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed bench: a behavioural memory responder with per-channel ack delays and stalls drives
// the handshake while hand-computed expectations are checked through checkOutput.
module tb_mem_port_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_rnw, req_priv;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_ready, rsp_abort, hang;
   logic [31:0] rsp_rdata;
   logic        access_r, mode_r, do_r, di_r, abort_r;
   logic        access_a, mode_a, do_a, di_a, abort_a;
   logic [37:0] access_d;
   logic        mode_d, abort_d;
   logic [31:0] do_d, di_d;

   // Responder state: ackV = {abort, di, do, mode, access}
   logic [4:0]  ackV = '0;
   logic [4:0]  holdV = '0;
   logic [4:0]  stallMask = '0;
   logic [4:0]  reqV;
   bit          autoMode = 1'b1;
   int          dly[5] = '{0, 0, 0, 0, 0};
   int          cnt[5] = '{0, 0, 0, 0, 0};
   logic [31:0] readWord = 32'hDEADBEEF;
   logic [31:0] wrAddr = '0, wrData = '0;

   int          checks = 0;
   int          failures = 0;

   logic [37:0] setupAccessD;
   logic        setupModeD, setupRLow;
   logic [31:0] lastRdata;
   logic        lastAbort, doAtAccess, diSeen, diEarly;
   int          lastLatency;

   assign {abort_a, di_a, do_a, mode_a, access_a} = ackV;
   assign abort_d = (access_d[32:17] == 16'hFFFF);
   assign di_d    = abort_d ? 32'hFFFFFFFF : readWord;

   mem_port_initiator #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw), .req_addr(req_addr),
      .req_size(req_size), .req_priv(req_priv), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_abort(rsp_abort),
      .hang(hang),
      .access_r(access_r), .access_a(access_a), .access_d(access_d),
      .mode_r(mode_r), .mode_a(mode_a), .mode_d(mode_d),
      .do_r(do_r), .do_a(do_a), .do_d(do_d),
      .di_r(di_r), .di_a(di_a), .di_d(di_d),
      .abort_r(abort_r), .abort_a(abort_a), .abort_d(abort_d)
   );

   always #5 clk = ~clk;

   // Memory responder: each ack follows its request after dly[k] extra cycles; Access waits for do_r on writes.
   always @(negedge clk) begin
      reqV = {abort_r, di_r, do_r, mode_r, access_r & (access_d[0] | do_r)} & ~stallMask;
      if (!autoMode) begin
         ackV = holdV;
         for (int k = 0; k < 5; k++) cnt[k] = 0;
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (ackV[k] != reqV[k]) begin
               if (cnt[k] >= dly[k]) begin
                  ackV[k] = reqV[k];
                  cnt[k] = 0;
                  if (k == 2 && reqV[k]) begin
                     wrAddr = access_d[32:1];
                     wrData = do_d;
                  end
               end else begin
                  cnt[k]++;
               end
            end else begin
               cnt[k] = 0;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic issueRequest(input logic rnw, input logic [31:0] addr, input logic [1:0] size,
                               input logic priv, input logic [31:0] wdata);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reqReadyWait", req_ready, 1);
      req_valid = 1'b1;
      req_rnw   = rnw;
      req_addr  = addr;
      req_size  = size;
      req_priv  = priv;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      setupAccessD = access_d;
      setupModeD   = mode_d;
      setupRLow    = !(access_r | mode_r | do_r | di_r | abort_r);
   endtask

   task automatic waitTxn();
      bit accSeen = 0;
      lastLatency = 0;
      diSeen = 0;
      diEarly = 0;
      doAtAccess = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         lastLatency++;
         if (access_r && !accSeen) begin
            accSeen = 1;
            doAtAccess = do_r;
         end
         if (di_r) diSeen = 1;
         if (di_r && !access_a) diEarly = 1;
         if (rsp_valid) begin
            lastRdata = rsp_rdata;
            lastAbort = rsp_abort;
         end
         if (req_ready) break;
      end
      checkOutput("txnDone", req_ready, 1);
   endtask

   task automatic applyStimulus(input logic rnw, input logic [31:0] addr, input logic [1:0] size,
                                input logic priv, input logic [31:0] wdata);
      issueRequest(rnw, addr, size, priv, wdata);
      waitTxn();
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0;
      req_rnw = 1'b0;
      req_addr = '0;
      req_size = '0;
      req_priv = 1'b0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstReqs", {access_r, mode_r, do_r, di_r, abort_r}, 0);
      checkOutput("rstAccessD", access_d, 0);
      checkOutput("rstRspValid", rsp_valid, 0);
      checkOutput("rstRdata", rsp_rdata, 0);
      checkOutput("rstHang", hang, 0);
      checkOutput("rstReady", req_ready, 1);

      // Word read, zero-delay acks: earliest ready is 5 + 3*2 cycles after accept.
      applyStimulus(1'b1, 32'h100, 2'd2, 1'b1, 32'h0);
      checkOutput("rdAccessD", setupAccessD, {3'b0, 2'd2, 32'h100, 1'b1});
      checkOutput("rdModeD", setupModeD, 1);
      checkOutput("rdSetupRLow", setupRLow, 1);
      checkOutput("rdData", lastRdata, 32'hDEADBEEF);
      checkOutput("rdAbort", lastAbort, 0);
      checkOutput("rdDiEarly", diEarly, 0);
      checkOutput("rdLatency", lastLatency, 11);

      applyStimulus(1'b0, 32'h3001, 2'd0, 1'b0, 32'h000000AB);
      checkOutput("wrAccessD", setupAccessD, {3'b0, 2'd0, 32'h3001, 1'b0});
      checkOutput("wrModeD", setupModeD, 0);
      checkOutput("wrDoWithAccess", doAtAccess, 1);
      checkOutput("wrNoDi", diSeen, 0);
      checkOutput("wrAddr", wrAddr, 32'h3001);
      checkOutput("wrByte", wrData[7:0], 8'hAB);
      checkOutput("wrRdata", lastRdata, 0);
      checkOutput("wrAbort", lastAbort, 0);

      // Out-of-range read with reserved size 3, presented as a word.
      applyStimulus(1'b1, 32'hFFFF0000, 2'd3, 1'b0, 32'h0);
      checkOutput("oorSize", setupAccessD[34:33], 2);
      checkOutput("oorData", lastRdata, 32'hFFFFFFFF);
      checkOutput("oorAbort", lastAbort, 1);

      // Skewed acks: mode 3 cycles after access, abort 5 after di; FSM follows the later ack.
      dly = '{0, 3, 0, 0, 5};
      applyStimulus(1'b1, 32'h100, 2'd2, 1'b0, 32'h0);
      checkOutput("skewLatency", lastLatency, 24);
      checkOutput("skewData", lastRdata, 32'hDEADBEEF);
      checkOutput("skewAbort", lastAbort, 0);
      dly = '{0, 0, 0, 0, 0};

      // Stalled do_a with a 16-cycle watchdog.
      stallMask = 5'b00100;
      issueRequest(1'b0, 32'h40, 2'd2, 1'b0, 32'h12345678);
      fork
         waitTxn();
         begin
            int n = 0;
            while (!abort_r && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            checkOutput("stallInData", abort_r, 1);
            repeat (10) @(posedge clk);
            #1;
            checkOutput("hangEarly", hang, 0);
            repeat (15) @(posedge clk);
            #1;
            checkOutput("hangSet", hang, 1);
            stallMask = 5'b00000;
         end
      join
      checkOutput("stallWrData", wrData, 32'h12345678);
      checkOutput("stallAbort", lastAbort, 0);
      checkOutput("hangSticky", hang, 1);

      // Reset while in DATA with the memory still holding acks.
      stallMask = 5'b01000;
      issueRequest(1'b1, 32'h200, 2'd2, 1'b0, 32'h0);
      begin
         int n = 0;
         while (!di_r && n < 50) begin
            @(posedge clk);
            #1;
            n++;
         end
         checkOutput("rstMidDiR", di_r, 1);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      holdV = 5'b00001;
      autoMode = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rstMidReqs", {access_r, mode_r, do_r, di_r, abort_r}, 0);
      checkOutput("rstMidHang", hang, 0);
      checkOutput("rstMidRspValid", rsp_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (i == 5 || i == 10) checkOutput("quiesceGate", req_ready, 0);
      end
      @(negedge clk);
      holdV = 5'b00000;
      stallMask = 5'b00000;
      autoMode = 1'b1;
      begin
         int n = 0;
         while (!req_ready && n < 6) begin
            @(posedge clk);
            #1;
            n++;
         end
         checkOutput("quiesceRelease", req_ready, 1);
      end
      applyStimulus(1'b1, 32'h100, 2'd2, 1'b0, 32'h0);
      checkOutput("recoverData", lastRdata, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
